// File: rtl/mem_port_arbiter_if.sv
// Bundles the IF/MEM requester ports and the SRAM/UART pin-side signals of the
// memory port arbiter; the arbiter uses the slave view.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_ack;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        if_stall;
    logic        mem_stall;
    logic [17:0] sram_addr;
    logic [15:0] sram_wdata;
    logic [15:0] sram_rdata;
    logic        sram_drive;
    logic        sram_en_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic        uart_rdn;
    logic        uart_wrn;
    logic        data_ready;
    logic        tbre;
    logic        tsre;

    modport slave (
        input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata,
        input  sram_rdata, data_ready, tbre, tsre,
        output if_rdata, if_ack, mem_rdata, mem_ack, if_stall, mem_stall,
        output sram_addr, sram_wdata, sram_drive, sram_en_n, sram_oe_n,
        output sram_we_n, uart_rdn, uart_wrn
    );

    modport master (
        output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata,
        output sram_rdata, data_ready, tbre, tsre,
        input  if_rdata, if_ack, mem_rdata, mem_ack, if_stall, mem_stall,
        input  sram_addr, sram_wdata, sram_drive, sram_en_n, sram_oe_n,
        input  sram_we_n, uart_rdn, uart_wrn
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one 16-bit SRAM and the UART between the IF and MEM requesters,
// sequencing the strobes and returning registered read data and ack pulses.
module mem_port_arbiter #(
    parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
    parameter logic [15:0] UART_STAT_ADDR = 16'hBF01
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_WR_SETUP, S_WR_STROBE, S_U_RD1, S_U_RD2, S_U_WR, S_U_WAIT
    } state_t;

    state_t      r_state;
    logic        r_owner_mem;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic        r_if_ack;
    logic        r_mem_ack;
    logic [15:0] r_if_rdata;
    logic [15:0] r_mem_rdata;
    logic        r_sram_en_n;
    logic        r_sram_oe_n;
    logic        r_sram_we_n;
    logic        r_sram_drive;
    logic        r_uart_rdn;
    logic        r_uart_wrn;

    state_t      w_state_next;
    logic        w_mem_elig;
    logic        w_if_elig;
    logic        w_load_req;
    logic        w_load_mem;
    logic        w_if_ack_next;
    logic        w_mem_ack_next;
    logic        w_cap_if;
    logic        w_cap_mem;
    logic [15:0] w_cap_data;
    logic        w_uart_idle;
    logic        w_sram_en_n_next;
    logic        w_sram_oe_n_next;
    logic        w_sram_we_n_next;
    logic        w_sram_drive_next;
    logic        w_uart_rdn_next;
    logic        w_uart_wrn_next;

    // A requester still holding its request during its ack cycle must not be regranted.
    assign w_mem_elig  = (bus.mem_rd | bus.mem_wr) & ~r_mem_ack;
    assign w_if_elig   = bus.if_req & ~r_if_ack;
    assign w_uart_idle = bus.tbre & bus.tsre;

    always_comb begin
        w_state_next   = r_state;
        w_load_req     = 1'b0;
        w_load_mem     = 1'b0;
        w_if_ack_next  = 1'b0;
        w_mem_ack_next = 1'b0;
        w_cap_if       = 1'b0;
        w_cap_mem      = 1'b0;
        w_cap_data     = bus.sram_rdata;
        case (r_state)
            S_IDLE: begin
                if (w_mem_elig) begin
                    if (bus.mem_addr == UART_DATA_ADDR) begin
                        w_load_req   = 1'b1;
                        w_load_mem   = 1'b1;
                        w_state_next = bus.mem_wr ? S_U_WR : S_U_RD1;
                    end else if (bus.mem_addr == UART_STAT_ADDR) begin
                        // Status is answered straight from IDLE; a write here is dropped.
                        w_mem_ack_next = 1'b1;
                        w_cap_mem      = ~bus.mem_wr;
                        w_cap_data     = {14'b0, bus.data_ready, w_uart_idle};
                    end else begin
                        w_load_req   = 1'b1;
                        w_load_mem   = 1'b1;
                        w_state_next = bus.mem_wr ? S_WR_SETUP : S_RD;
                    end
                end else if (w_if_elig) begin
                    w_load_req   = 1'b1;
                    w_state_next = S_RD;
                end
            end
            S_RD: begin
                w_state_next   = S_IDLE;
                w_mem_ack_next = r_owner_mem;
                w_if_ack_next  = ~r_owner_mem;
                w_cap_mem      = r_owner_mem;
                w_cap_if       = ~r_owner_mem;
            end
            S_WR_SETUP:  w_state_next = S_WR_STROBE;
            S_WR_STROBE: begin
                w_state_next   = S_IDLE;
                w_mem_ack_next = 1'b1;
            end
            S_U_RD1: w_state_next = S_U_RD2;
            S_U_RD2: begin
                w_state_next   = S_IDLE;
                w_mem_ack_next = 1'b1;
                w_cap_mem      = 1'b1;
                w_cap_data     = {8'b0, bus.sram_rdata[7:0]};
            end
            S_U_WR, S_U_WAIT: begin
                if (w_uart_idle) begin
                    w_state_next   = S_IDLE;
                    w_mem_ack_next = 1'b1;
                end else begin
                    w_state_next = S_U_WAIT;
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        // Strobes are decoded from the next state so the pins come straight from flops.
        w_sram_en_n_next  = 1'b1;
        w_sram_oe_n_next  = 1'b1;
        w_sram_we_n_next  = 1'b1;
        w_sram_drive_next = 1'b0;
        w_uart_rdn_next   = 1'b1;
        w_uart_wrn_next   = 1'b1;
        case (w_state_next)
            S_RD: begin
                w_sram_en_n_next = 1'b0;
                w_sram_oe_n_next = 1'b0;
            end
            S_WR_SETUP: begin
                w_sram_en_n_next  = 1'b0;
                w_sram_drive_next = 1'b1;
            end
            S_WR_STROBE: begin
                w_sram_en_n_next  = 1'b0;
                w_sram_we_n_next  = 1'b0;
                w_sram_drive_next = 1'b1;
            end
            S_U_RD1, S_U_RD2: w_uart_rdn_next = 1'b0;
            S_U_WR: begin
                w_uart_wrn_next   = 1'b0;
                w_sram_drive_next = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_owner_mem  <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_if_ack     <= 1'b0;
            r_mem_ack    <= 1'b0;
            r_if_rdata   <= '0;
            r_mem_rdata  <= '0;
            r_sram_en_n  <= 1'b1;
            r_sram_oe_n  <= 1'b1;
            r_sram_we_n  <= 1'b1;
            r_sram_drive <= 1'b0;
            r_uart_rdn   <= 1'b1;
            r_uart_wrn   <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_if_ack  <= w_if_ack_next;
            r_mem_ack <= w_mem_ack_next;
            if (w_load_req) begin
                r_owner_mem <= w_load_mem;
                r_addr      <= w_load_mem ? bus.mem_addr : bus.if_addr;
                if (w_load_mem) begin
                    r_wdata <= bus.mem_wdata;
                end
            end
            if (w_cap_if) begin
                r_if_rdata <= w_cap_data;
            end
            if (w_cap_mem) begin
                r_mem_rdata <= w_cap_data;
            end
            r_sram_en_n  <= w_sram_en_n_next;
            r_sram_oe_n  <= w_sram_oe_n_next;
            r_sram_we_n  <= w_sram_we_n_next;
            r_sram_drive <= w_sram_drive_next;
            r_uart_rdn   <= w_uart_rdn_next;
            r_uart_wrn   <= w_uart_wrn_next;
        end
    end

    assign bus.if_rdata   = r_if_rdata;
    assign bus.if_ack     = r_if_ack;
    assign bus.mem_rdata  = r_mem_rdata;
    assign bus.mem_ack    = r_mem_ack;
    assign bus.if_stall   = bus.if_req & ~r_if_ack;
    assign bus.mem_stall  = (bus.mem_rd | bus.mem_wr) & ~r_mem_ack;
    assign bus.sram_addr  = {2'b00, r_addr};
    assign bus.sram_wdata = r_wdata;
    assign bus.sram_drive = r_sram_drive;
    assign bus.sram_en_n  = r_sram_en_n;
    assign bus.sram_oe_n  = r_sram_oe_n;
    assign bus.sram_we_n  = r_sram_we_n;
    assign bus.uart_rdn   = r_uart_rdn;
    assign bus.uart_wrn   = r_uart_wrn;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change 1 time unit after the rising
// edge, outputs are checked on the falling edge of the same cycle.
module tb_mem_port_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(
        .UART_DATA_ADDR(16'hBF00),
        .UART_STAT_ADDR(16'hBF01)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        bus.if_req     = 1'b0;
        bus.if_addr    = '0;
        bus.mem_rd     = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.sram_rdata = '0;
        bus.data_ready = 1'b0;
        bus.tbre       = 1'b1;
        bus.tsre       = 1'b1;

        // Reset state
        next_cycle();
        next_cycle();
        to_neg();
        chk("rst_if_ack", bus.if_ack, 0);
        chk("rst_mem_ack", bus.mem_ack, 0);
        chk("rst_if_rdata", bus.if_rdata, 0);
        chk("rst_mem_rdata", bus.mem_rdata, 0);
        chk("rst_strobes", {bus.sram_en_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_drive,
                            bus.uart_rdn, bus.uart_wrn}, 6'b111011);
        chk("rst_sram_addr", bus.sram_addr, 0);
        $display("txn reset done");
        next_cycle();
        rst = 1'b0;

        // IF read 0x0040 -> 0x1234
        next_cycle();
        bus.if_req = 1'b1; bus.if_addr = 16'h0040; bus.sram_rdata = 16'h1234;
        to_neg();
        chk("t1_k_if_stall", bus.if_stall, 1);
        chk("t1_k_en_n", bus.sram_en_n, 1);
        next_cycle(); to_neg();
        chk("t1_k1_rd_strobes", {bus.sram_en_n, bus.sram_oe_n, bus.sram_drive}, 3'b000);
        chk("t1_k1_addr", bus.sram_addr, 18'h00040);
        chk("t1_k1_if_stall", bus.if_stall, 1);
        chk("t1_k1_if_ack", bus.if_ack, 0);
        next_cycle(); to_neg();
        chk("t1_k2_if_ack", bus.if_ack, 1);
        chk("t1_k2_if_rdata", bus.if_rdata, 16'h1234);
        chk("t1_k2_if_stall", bus.if_stall, 0);
        chk("t1_k2_en_n", bus.sram_en_n, 1);
        next_cycle();
        bus.if_req = 1'b0;
        to_neg();
        chk("t1_k3_if_ack", bus.if_ack, 0);
        chk("t1_k3_if_rdata_held", bus.if_rdata, 16'h1234);
        $display("txn if_read addr=0040 data=%h", bus.if_rdata);

        // MEM write 0x8000<-0xBEEF with a simultaneous IF read 0x0050
        next_cycle();
        bus.mem_wr = 1'b1; bus.mem_addr = 16'h8000; bus.mem_wdata = 16'hBEEF;
        bus.if_req = 1'b1; bus.if_addr = 16'h0050; bus.sram_rdata = 16'h7777;
        to_neg();
        chk("t2_k_stalls", {bus.mem_stall, bus.if_stall}, 2'b11);
        chk("t2_k_drive", bus.sram_drive, 0);
        next_cycle(); to_neg();
        chk("t2_k1_setup", {bus.sram_en_n, bus.sram_we_n, bus.sram_drive, bus.sram_oe_n}, 4'b0111);
        chk("t2_k1_addr", bus.sram_addr, 18'h08000);
        chk("t2_k1_wdata", bus.sram_wdata, 16'hBEEF);
        next_cycle(); to_neg();
        chk("t2_k2_strobe", {bus.sram_en_n, bus.sram_we_n, bus.sram_drive}, 3'b001);
        chk("t2_k2_addr", bus.sram_addr, 18'h08000);
        chk("t2_k2_mem_ack", bus.mem_ack, 0);
        next_cycle(); to_neg();
        chk("t2_k3_mem_ack", bus.mem_ack, 1);
        chk("t2_k3_idle", {bus.sram_we_n, bus.sram_drive, bus.sram_en_n}, 3'b101);
        chk("t2_k3_stalls", {bus.mem_stall, bus.if_stall}, 2'b01);
        next_cycle();
        bus.mem_wr = 1'b0;
        to_neg();
        chk("t2_k4_if_rd", {bus.sram_en_n, bus.sram_oe_n}, 2'b00);
        chk("t2_k4_addr", bus.sram_addr, 18'h00050);
        chk("t2_k4_mem_ack", bus.mem_ack, 0);
        next_cycle(); to_neg();
        chk("t2_k5_if_ack", bus.if_ack, 1);
        chk("t2_k5_if_rdata", bus.if_rdata, 16'h7777);
        next_cycle();
        bus.if_req = 1'b0;
        $display("txn mem_write 8000=BEEF then if_read 0050=%h", bus.if_rdata);

        // Status read 0xBF01
        next_cycle();
        bus.mem_rd = 1'b1; bus.mem_addr = 16'hBF01;
        bus.data_ready = 1'b1; bus.tbre = 1'b1; bus.tsre = 1'b0;
        to_neg();
        chk("t3_k_mem_ack", bus.mem_ack, 0);
        next_cycle(); to_neg();
        chk("t3_k1_mem_ack", bus.mem_ack, 1);
        chk("t3_k1_mem_rdata", bus.mem_rdata, 16'h0002);
        chk("t3_k1_no_strobe", {bus.sram_en_n, bus.sram_oe_n, bus.sram_we_n,
                                bus.uart_rdn, bus.uart_wrn}, 5'b11111);
        next_cycle();
        bus.mem_rd = 1'b0; bus.data_ready = 1'b0; bus.tsre = 1'b1;
        to_neg();
        chk("t3_k2_mem_ack", bus.mem_ack, 0);
        $display("txn status_read data=%h", bus.mem_rdata);

        // UART write 0xBF00<-0x0041, tbre low for 3 cycles after U_WR
        next_cycle();
        bus.mem_wr = 1'b1; bus.mem_addr = 16'hBF00; bus.mem_wdata = 16'h0041; bus.tbre = 1'b0;
        to_neg();
        chk("t4_k_wrn", bus.uart_wrn, 1);
        next_cycle(); to_neg();
        chk("t4_k1_uwr", {bus.uart_wrn, bus.sram_drive, bus.sram_en_n}, 3'b011);
        chk("t4_k1_wdata", bus.sram_wdata, 16'h0041);
        for (int i = 2; i <= 4; i++) begin
            next_cycle(); to_neg();
            chk($sformatf("t4_k%0d_wait", i), {bus.uart_wrn, bus.mem_ack, bus.sram_drive}, 3'b100);
        end
        next_cycle();
        bus.tbre = 1'b1;
        to_neg();
        chk("t4_k5_mem_ack", bus.mem_ack, 0);
        next_cycle(); to_neg();
        chk("t4_k6_mem_ack", bus.mem_ack, 1);
        next_cycle();
        bus.mem_wr = 1'b0;
        to_neg();
        chk("t4_k7_mem_ack", bus.mem_ack, 0);
        $display("txn uart_write data=0041 done");

        // UART read 0xBF00 with pad 0xFF5A
        next_cycle();
        bus.mem_rd = 1'b1; bus.mem_addr = 16'hBF00; bus.sram_rdata = 16'hFF5A;
        to_neg();
        chk("t5_k_rdn", bus.uart_rdn, 1);
        next_cycle(); to_neg();
        chk("t5_k1_rdn", {bus.uart_rdn, bus.sram_en_n}, 2'b01);
        next_cycle(); to_neg();
        chk("t5_k2_rdn", {bus.uart_rdn, bus.mem_ack}, 2'b00);
        next_cycle(); to_neg();
        chk("t5_k3_rdn", bus.uart_rdn, 1);
        chk("t5_k3_mem_ack", bus.mem_ack, 1);
        chk("t5_k3_mem_rdata", bus.mem_rdata, 16'h005A);
        next_cycle();
        bus.mem_rd = 1'b0;
        $display("txn uart_read data=%h", bus.mem_rdata);

        // Reset during WR_STROBE, then re-issued write
        next_cycle();
        bus.mem_wr = 1'b1; bus.mem_addr = 16'h1234; bus.mem_wdata = 16'hCAFE;
        next_cycle(); to_neg();
        chk("t6_k1_setup", {bus.sram_drive, bus.sram_we_n}, 2'b11);
        next_cycle();
        rst = 1'b1;
        to_neg();
        chk("t6_k2_we_n", bus.sram_we_n, 0);
        next_cycle();
        rst = 1'b0;
        to_neg();
        chk("t6_k3_aborted", {bus.sram_we_n, bus.sram_drive, bus.sram_en_n, bus.mem_ack}, 4'b1010);
        chk("t6_k3_mem_rdata", bus.mem_rdata, 0);
        next_cycle(); to_neg();
        chk("t6_k4_setup", {bus.sram_drive, bus.sram_we_n, bus.mem_ack}, 3'b110);
        chk("t6_k4_addr", bus.sram_addr, 18'h01234);
        next_cycle(); to_neg();
        chk("t6_k5_strobe", {bus.sram_we_n, bus.mem_ack}, 2'b00);
        chk("t6_k5_wdata", bus.sram_wdata, 16'hCAFE);
        next_cycle(); to_neg();
        chk("t6_k6_mem_ack", bus.mem_ack, 1);
        next_cycle();
        bus.mem_wr = 1'b0;
        $display("txn reset_abort then write 1234=CAFE done");

        next_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port memory arbiter that shares one 16-bit external SRAM and the UART between the instruction-fetch requester and the MEM-stage data requester of the pipeline. It sequences the SRAM strobes and the UART rdn/wrn handshake, returns read data, and generates per-requester stall signals for the hazard unit. It sits between the IF/MEM pipeline stages and the board SRAM/UART pins. The tristate data pad lives outside this block.

## Interface
Parameters:
- UART_DATA_ADDR, 16'hBF00, address mapped to the UART data register
- UART_STAT_ADDR, 16'hBF01, address mapped to the UART status word

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  instruction fetch request, held until if_ack
- if_addr  in  16  fetch address
- if_rdata  out  16  fetched word, valid while if_ack=1, held afterwards
- if_ack  out  1  one-cycle completion pulse for IF
- mem_rd / mem_wr  in  1 / 1  data read / write request, held until mem_ack
- mem_addr  in  16  data address
- mem_wdata  in  16  store data
- mem_rdata  out  16  load data, valid while mem_ack=1, held afterwards
- mem_ack  out  1  one-cycle completion pulse for MEM
- if_stall / mem_stall  out  1 / 1  request pending and not acked this cycle
- sram_addr  out  18  {2'b00, granted address}
- sram_wdata  out  16  data to pad
- sram_rdata  in  16  data from pad
- sram_drive  out  1  1 = pad drives sram_wdata
- sram_en_n / sram_oe_n / sram_we_n  out  1 / 1 / 1  SRAM chip enable, output enable, write enable (active low)
- uart_rdn / uart_wrn  out  1 / 1  UART read and write strobes (active low)
- data_ready, tbre, tsre  in  1 each  UART status inputs

## Operation
- FSM states: IDLE, RD, WR_SETUP, WR_STROBE, U_RD1, U_RD2, U_WR, U_WAIT.
- Grant happens in IDLE only.
- MEM has strict priority over IF.
- A requester whose ack is high in the current cycle is not eligible.
- If mem_rd and mem_wr are both high, the request is treated as a write.
- Address decode of the granted request:
  - mem_addr == UART_DATA_ADDR selects the UART path (rd → U_RD1, wr → U_WR).
  - mem_addr == UART_STAT_ADDR read completes from IDLE with no bus activity. mem_rdata = {14'b0, data_ready, tbre & tsre}.
  - A write to UART_STAT_ADDR is acked and discarded.
  - IF requests always go to SRAM.
- RD: sram_en_n=0, sram_oe_n=0, sram_drive=0. sram_rdata is captured at the end of RD.
- WR_SETUP: sram_en_n=0, sram_drive=1, address and data stable, sram_we_n=1.
- WR_STROBE: sram_we_n=0. Address and data stay stable.
- U_RD1, U_RD2: uart_rdn=0 and the SRAM is disabled. sram_rdata[7:0] is captured at the end of U_RD2 and zero-extended.
- U_WR: uart_wrn=0 and sram_drive=1 (data on pad).
- U_WAIT: uart_wrn=1. The FSM stays here until tbre & tsre = 1.
- Completion of any access registers the ack pulse and read data and returns the FSM to IDLE.
- When no access is in progress: sram_en_n=1, oe_n=1, we_n=1, drive=0, rdn=1, wrn=1.
- Stall outputs are combinational:
  - if_stall = if_req & ~if_ack
  - mem_stall = (mem_rd | mem_wr) & ~mem_ack

## Timing
- Request sampled high in IDLE at edge k → grant at edge k. Ack is high in the stated cycle after edge k:
  - SRAM read: cycle k+2 (RD during k+1)
  - SRAM write: cycle k+3
  - Status read: cycle k+1
  - UART read: cycle k+3
  - UART write: cycle k+2 at the earliest. It is extended by one cycle per cycle spent in U_WAIT.
- During the ack cycle the FSM is in IDLE. The other requester may be granted in that same cycle.
- Back-to-back grants to the same requester have a minimum gap of one idle cycle.
- Reset values: FSM=IDLE, if_ack=0, mem_ack=0, if_rdata=0, mem_rdata=0, sram_en_n=1, sram_oe_n=1, sram_we_n=1, sram_drive=0, uart_rdn=1, uart_wrn=1, sram_addr=0.
- Reset mid-operation aborts the access at that edge. All strobes deassert, no ack is issued, and no data is captured.
- An IF request that arrives while MEM is busy waits. IF latency grows by the remaining MEM access time.

## Test plan
- Reset, then an IF read of 0x0040 with sram_rdata=0x1234: RD in cycle k+1, if_ack=1 and if_rdata=0x1234 in cycle k+2, if_stall=1 in cycles k and k+1.
- MEM write 0x8000←0xBEEF and IF read raised in the same cycle: write goes first (we_n low only in k+2, drive=1 in k+1..k+2), mem_ack at k+3. The IF read is granted in the k+3 cycle and if_ack arrives at k+5.
- MEM read of 0xBF01 with data_ready=1, tbre=1, tsre=0: mem_rdata=0x0002 and mem_ack at k+1, with no SRAM or UART strobe.
- MEM write 0xBF00←0x0041, with tbre held low for 3 cycles after U_WR: uart_wrn low exactly one cycle, mem_ack exactly one cycle after tbre&tsre rises.
- MEM read 0xBF00 with sram_rdata=0xFF5A: uart_rdn low for 2 cycles, mem_rdata=0x005A.
- rst asserted during WR_STROBE: the next cycle has we_n=1, drive=0 and no mem_ack. A re-issued write completes normally.
